iob_post_queue: RTL and testbench
=================================

Name: iob_post_queue

Overview:
- Parametrised successor to the IO bus slave's fixed two-level posted-write latch pair.
- Sits between FSB cycle decode (BACT, IOCS, IOPWCS) and the IOB master. It queues up to DEPTH posted writes (address, data, byte strobes) and drains them in order to the IOB master.
- Non-posted accesses (reads, and writes outside the posted-write region) are strictly ordered behind all queued writes. They complete the FSB cycle only after the IOB transaction finishes.

Parameters:
- DEPTH, 4, number of posted-write entries; legal 2..8.
- AW, 23, FSB address width; the address bus is A[AW:1].
- DW, 16, data width.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
- CLK  in  1  FSB clock.
- nRES  in  1  asynchronous active-low reset.
- BACT  in  1  FSB /AS cycle active, synchronous to CLK.
- IOCS  in  1  IO space select, valid while BACT.
- IOPWCS  in  1  posted-write-eligible select, valid while BACT; implies IOCS.
- nWE  in  1  FSB write strobe, low = write.
- nLDS  in  1  FSB lower data strobe.
- nUDS  in  1  FSB upper data strobe.
- A  in  AW  FSB address A[AW:1].
- DI  in  DW  FSB write data.
- IOPWReady  out  1  posted write accepted; terminate the FSB cycle.
- IONPReady  out  1  non-posted access complete; terminate the FSB cycle.
- nBERR_FSB  out  1  bus error to FSB, non-posted only.
- DO  out  DW  read data returned for a non-posted read.
- IOREQ  out  1  request to the IOB master.
- IORW  out  1  1 = read, 0 = write, for the current request.
- IOA  out  AW  request address.
- IOD  out  DW  request write data.
- IOL0  out  1  request lower byte enable.
- IOU0  out  1  request upper byte enable.
- IOACT  in  1  IOB master has taken the request; synchronised to CLK.
- IODONE  in  1  one-cycle pulse, IOB transaction finished; synchronised to CLK.
- IORD  in  DW  IOB read data, valid in the IODONE cycle.
- BERR_IOB  in  1  active-high IOB bus error, sampled with IODONE.
- PWErr  out  1  sticky flag: a posted write received BERR; cleared only by reset.
- Count  out  CW  number of queued posted writes.

Behaviour:
- Reset, asynchronous on nRES low: queue empty, Count=0, pointers=0.
  - IOREQ=0, IOPWReady=0, IONPReady=0, nBERR_FSB=1, PWErr=0, DO=0.
  - IORW=1, IOL0=0, IOU0=0, IOA=0, IOD=0.
  - Both FSMs go to idle.
  - An in-flight request is abandoned and no retire occurs.
- Cycle start is the BACT rising edge, registered internally as BACTr.
- FSB FSM states: F_IDLE, F_PW, F_NPWAIT, F_NPBUSY, F_TERM.
  - At cycle start in F_IDLE:
    - If IOPWCS & !nWE, go to F_PW.
    - Else if IOCS, go to F_NPWAIT.
    - Else stay in F_IDLE.
  - F_PW: enqueue {A, DI, !nLDS, !nUDS} in the first cycle in which Count<DEPTH or a retire occurs in that same cycle. IOPWReady rises the following cycle, then go to F_TERM. Minimum latency is 1 CLK after BACT rises.
  - F_NPWAIT: when Count=0 and the master FSM is idle, load the request registers with the live FSB values and go to F_NPBUSY.
  - F_NPBUSY: on IODONE, latch DO=IORD (reads only) and set nBERR_FSB=!BERR_IOB. Then IONPReady=1 unless BERR_IOB was set, and go to F_TERM.
  - F_TERM: hold IOPWReady, IONPReady and nBERR_FSB until BACT=0, then clear them all and go to F_IDLE.
- Master FSM states: M_IDLE, M_REQ, M_ACT.
  - M_IDLE: start when the queue is non-empty (head entry) or a non-posted access is loaded. Drive IOA/IOD/IOL0/IOU0/IORW and go to M_REQ.
  - M_REQ: IOREQ=1. On IOACT, go to M_ACT.
  - M_ACT: IOREQ=0. On IODONE, retire the head (posted), go to M_IDLE. The next request's IOREQ rises no earlier than the cycle after IODONE.
  - Request fields are stable from M_IDLE exit to IODONE.
- Queue:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Enqueue and retire in the same cycle leave Count unchanged.
  - Enqueue when Count=DEPTH without a same-cycle retire is forbidden; F_PW stalls instead.
- Ordering: requests issue in FSB order. A non-posted access never overtakes a queued write.
- Posted-write error: on IODONE with BERR_IOB for a posted entry, set PWErr=1. The entry still retires and the FSB is not notified.
- BACT falling early in F_PW or F_NPWAIT (aborted cycle): the cycle is discarded with no enqueue and no request. An already-issued non-posted request still completes at the IOB, but its result is dropped.

Test Plan:
- Single posted write A=0x580000, DI=0xA55A, LDS/UDS both low: IOPWReady=1 one CLK after BACT rises; IOREQ with IOA=0x580000, IOD=0xA55A, IOL0=IOU0=1; Count goes 1→0 after IODONE.
- DEPTH=4, five back-to-back posted writes, IOACT held low: first four get IOPWReady; fifth stalls with Count=4; IOPWReady for the fifth follows the first IODONE by 1 CLK.
- Three queued writes, then a read: IOREQ for the read appears only after the third IODONE; DO=IORD=0x1234; IONPReady=1 until BACT falls.
- Non-posted write with BERR_IOB=1 at IODONE: nBERR_FSB=0, IONPReady stays 0. The same error on a posted write: PWErr=1, nBERR_FSB stays 1, Count decrements.
- Simultaneous enqueue and retire with Count=2: Count stays 2; write pointer and read pointer wrap correctly over 3×DEPTH writes; data order is preserved.
- nRES asserted in M_ACT with Count=3: all outputs take their reset values immediately; a late IODONE after reset is ignored, with Count staying 0.

Source files
------------

// File: rtl/iob_post_queue.sv
// IO bus posted-write queue: buffers up to DEPTH FSB posted writes and drains them
// in order to the IOB master; non-posted accesses wait behind them and end synchronously.
module iob_post_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 23,
    parameter int DW    = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRES,
    input  logic          BACT,
    input  logic          IOCS,
    input  logic          IOPWCS,
    input  logic          nWE,
    input  logic          nLDS,
    input  logic          nUDS,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DI,
    output logic          IOPWReady,
    output logic          IONPReady,
    output logic          nBERR_FSB,
    output logic [DW-1:0] DO,
    output logic          IOREQ,
    output logic          IORW,
    output logic [AW-1:0] IOA,
    output logic [DW-1:0] IOD,
    output logic          IOL0,
    output logic          IOU0,
    input  logic          IOACT,
    input  logic          IODONE,
    input  logic [DW-1:0] IORD,
    input  logic          BERR_IOB,
    output logic          PWErr,
    output logic [CW-1:0] Count
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {F_IDLE, F_PW, F_NPWAIT, F_NPBUSY, F_TERM} fState_t;
    typedef enum logic [1:0] {M_IDLE, M_REQ, M_ACT} mState_t;

    fState_t         fState;
    mState_t         mState;
    logic            BACTr;
    logic            npPend;
    logic            mNp;
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic [AW-1:0]   addrQ [DEPTH];
    logic [DW-1:0]   dataQ [DEPTH];
    logic [1:0]      beQ   [DEPTH];

    logic start;
    logic retire;
    logic npDone;
    logic canEnq;
    logic enq;

    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start  = BACT & ~BACTr;
    assign retire = (mState == M_ACT) & IODONE & ~mNp;
    assign npDone = (mState == M_ACT) & IODONE & mNp;
    // A full queue still accepts when the head retires in the same cycle.
    assign canEnq = (Count < CW'(DEPTH)) | retire;
    assign enq    = canEnq & (((fState == F_IDLE) & start & IOPWCS & ~nWE) |
                              ((fState == F_PW) & BACT));

    always_ff @(posedge CLK) begin
        if (enq) begin
            addrQ[wrPtr] <= A;
            dataQ[wrPtr] <= DI;
            beQ[wrPtr]   <= {~nUDS, ~nLDS};
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            fState    <= F_IDLE;
            mState    <= M_IDLE;
            BACTr     <= 1'b0;
            npPend    <= 1'b0;
            mNp       <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            Count     <= '0;
            IOPWReady <= 1'b0;
            IONPReady <= 1'b0;
            nBERR_FSB <= 1'b1;
            DO        <= '0;
            PWErr     <= 1'b0;
            IOREQ     <= 1'b0;
            IORW      <= 1'b1;
            IOA       <= '0;
            IOD       <= '0;
            IOL0      <= 1'b0;
            IOU0      <= 1'b0;
        end else begin
            BACTr <= BACT;

            if (enq)    wrPtr <= nextPtr(wrPtr);
            if (retire) rdPtr <= nextPtr(rdPtr);
            if (enq & ~retire)      Count <= Count + 1'b1;
            else if (retire & ~enq) Count <= Count - 1'b1;
            if (retire & BERR_IOB)  PWErr <= 1'b1;

            case (fState)
                F_IDLE: begin
                    if (start) begin
                        if (IOPWCS & ~nWE) begin
                            if (enq) begin
                                IOPWReady <= 1'b1;
                                fState    <= F_TERM;
                            end else begin
                                fState <= F_PW;
                            end
                        end else if (IOCS) begin
                            fState <= F_NPWAIT;
                        end
                    end
                end
                F_PW: begin
                    if (!BACT) begin
                        fState <= F_IDLE;
                    end else if (enq) begin
                        IOPWReady <= 1'b1;
                        fState    <= F_TERM;
                    end
                end
                F_NPWAIT: begin
                    if (!BACT) begin
                        fState <= F_IDLE;
                    end else if ((Count == '0) && (mState == M_IDLE) && !npPend) begin
                        IOA    <= A;
                        IOD    <= DI;
                        IORW   <= nWE;
                        IOL0   <= ~nLDS;
                        IOU0   <= ~nUDS;
                        npPend <= 1'b1;
                        fState <= F_NPBUSY;
                    end
                end
                F_NPBUSY: begin
                    // An abandoned cycle lets the IOB access finish but drops its result.
                    if (!BACT) begin
                        fState <= F_IDLE;
                    end else if (npDone) begin
                        if (IORW) DO <= IORD;
                        nBERR_FSB <= ~BERR_IOB;
                        IONPReady <= ~BERR_IOB;
                        fState    <= F_TERM;
                    end
                end
                F_TERM: begin
                    if (!BACT) begin
                        IOPWReady <= 1'b0;
                        IONPReady <= 1'b0;
                        nBERR_FSB <= 1'b1;
                        fState    <= F_IDLE;
                    end
                end
                default: fState <= F_IDLE;
            endcase

            case (mState)
                M_IDLE: begin
                    if (npPend) begin
                        npPend <= 1'b0;
                        mNp    <= 1'b1;
                        IOREQ  <= 1'b1;
                        mState <= M_REQ;
                    end else if (Count != '0) begin
                        IOA    <= addrQ[rdPtr];
                        IOD    <= dataQ[rdPtr];
                        IOL0   <= beQ[rdPtr][0];
                        IOU0   <= beQ[rdPtr][1];
                        IORW   <= 1'b0;
                        mNp    <= 1'b0;
                        IOREQ  <= 1'b1;
                        mState <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (IOACT) begin
                        IOREQ  <= 1'b0;
                        mState <= M_ACT;
                    end
                end
                M_ACT: begin
                    if (IODONE) mState <= M_IDLE;
                end
                default: mState <= M_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_post_queue.sv
// Directed bench for iob_post_queue: vector tables for single posted and non-posted
// accesses, plus hand-written stall, ordering, wrap, abort, error and reset sequences.
`timescale 1ns/1ps
module tb_iob_post_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          nRES = 1'b0;
    logic          BACT = 1'b0, IOCS = 1'b0, IOPWCS = 1'b0;
    logic          nWE = 1'b1, nLDS = 1'b1, nUDS = 1'b1;
    logic [AW-1:0] A = '0;
    logic [DW-1:0] DI = '0;
    logic          IOPWReady, IONPReady, nBERR_FSB;
    logic [DW-1:0] DO;
    logic          IOREQ, IORW, IOL0, IOU0;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic          IOACT = 1'b0, IODONE = 1'b0, BERR_IOB = 1'b0;
    logic [DW-1:0] IORD = '0;
    logic          PWErr;
    logic [CW-1:0] Count;

    int nCmp = 0;
    int nBad = 0;

    iob_post_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .nRES(nRES), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS),
        .nWE(nWE), .nLDS(nLDS), .nUDS(nUDS), .A(A), .DI(DI),
        .IOPWReady(IOPWReady), .IONPReady(IONPReady), .nBERR_FSB(nBERR_FSB), .DO(DO),
        .IOREQ(IOREQ), .IORW(IORW), .IOA(IOA), .IOD(IOD), .IOL0(IOL0), .IOU0(IOU0),
        .IOACT(IOACT), .IODONE(IODONE), .IORD(IORD), .BERR_IOB(BERR_IOB),
        .PWErr(PWErr), .Count(Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          nl;
        logic          nu;
        logic          expL;
        logic          expU;
    } pwVec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] rd;
        logic          berr;
        logic [DW-1:0] expDO;
        logic          expNB;
        logic          expRdy;
    } npVec_t;

    pwVec_t pwTab [4];
    npVec_t npTab [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!IOREQ && n < 60) begin
            step();
            n++;
        end
        nCmp++;
        if (!IOREQ) begin
            nBad++;
            $display("FAIL %s: IOREQ still 0 after 60 cycles, expected 1", name);
        end
    endtask

    task automatic ack();
        IOACT = 1'b1;
        step();
        IOACT = 1'b0;
    endtask

    task automatic done(input logic [DW-1:0] rd, input logic berr);
        IODONE = 1'b1;
        IORD = rd;
        BERR_IOB = berr;
        step();
        IODONE = 1'b0;
        BERR_IOB = 1'b0;
        IORD = '0;
    endtask

    task automatic fsbGo(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                         input logic pw, input logic nl, input logic nu);
        A = a; DI = d; nWE = ~we; IOCS = 1'b1; IOPWCS = pw; nLDS = nl; nUDS = nu;
        BACT = 1'b1;
    endtask

    task automatic fsbEnd();
        BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; nWE = 1'b1; nLDS = 1'b1; nUDS = 1'b1;
        step();
    endtask

    task automatic postWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        fsbGo(a, d, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("postWrite.ready", 32'(IOPWReady), 1);
        fsbEnd();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pwTab[0] = '{23'h580000, 16'hA55A, 1'b0, 1'b0, 1'b1, 1'b1};
        pwTab[1] = '{23'h580002, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
        pwTab[2] = '{23'h7FFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        pwTab[3] = '{23'h000000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1};

        npTab[0] = '{23'h580010, 1'b0, 16'hCAFE, 1'b0, 16'hCAFE, 1'b1, 1'b1};
        npTab[1] = '{23'h580020, 1'b1, 16'hBEEF, 1'b1, 16'hCAFE, 1'b0, 1'b0};
        npTab[2] = '{23'h580030, 1'b0, 16'h5678, 1'b0, 16'h5678, 1'b1, 1'b1};
        npTab[3] = '{23'h580040, 1'b1, 16'h0F0F, 1'b0, 16'h5678, 1'b1, 1'b1};

        // Reset state
        step(); step();
        check("rst.IOREQ", 32'(IOREQ), 0);
        check("rst.IORW", 32'(IORW), 1);
        check("rst.nBERR", 32'(nBERR_FSB), 1);
        check("rst.Count", 32'(Count), 0);
        check("rst.IOPWReady", 32'(IOPWReady), 0);
        check("rst.IONPReady", 32'(IONPReady), 0);
        check("rst.DO", 32'(DO), 0);
        nRES = 1'b1;
        step();

        // Single posted writes
        for (int i = 0; i < 4; i++) begin
            fsbGo(pwTab[i].a, pwTab[i].d, 1'b1, 1'b1, pwTab[i].nl, pwTab[i].nu);
            step();
            check("pw.ready", 32'(IOPWReady), 1);
            check("pw.count", 32'(Count), 1);
            fsbEnd();
            check("pw.readyClr", 32'(IOPWReady), 0);
            waitReq("pw.req");
            check("pw.IOA", 32'(IOA), 32'(pwTab[i].a));
            check("pw.IOD", 32'(IOD), 32'(pwTab[i].d));
            check("pw.IOL0", 32'(IOL0), 32'(pwTab[i].expL));
            check("pw.IOU0", 32'(IOU0), 32'(pwTab[i].expU));
            check("pw.IORW", 32'(IORW), 0);
            ack();
            check("pw.reqDrop", 32'(IOREQ), 0);
            check("pw.countBusy", 32'(Count), 1);
            done('0, 1'b0);
            check("pw.countDone", 32'(Count), 0);
        end

        // Three queued writes, then a read that must wait for all of them
        for (int k = 0; k < 3; k++) postWrite(AW'(32'h200000 + 2 * k), DW'(32'h3000 + k));
        check("ord.count", 32'(Count), 3);
        fsbGo(23'h580100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            waitReq("ord.wreq");
            check("ord.wIORW", 32'(IORW), 0);
            check("ord.wIOA", 32'(IOA), 32'h200000 + 2 * k);
            check("ord.npPending", 32'(IONPReady), 0);
            ack();
            done('0, 1'b0);
        end
        waitReq("ord.rreq");
        check("ord.rIORW", 32'(IORW), 1);
        check("ord.rIOA", 32'(IOA), 32'h580100);
        ack();
        done(16'h1234, 1'b0);
        check("ord.DO", 32'(DO), 32'h1234);
        check("ord.npReady", 32'(IONPReady), 1);
        step(); step();
        check("ord.npHold", 32'(IONPReady), 1);
        fsbEnd();
        check("ord.npClr", 32'(IONPReady), 0);

        // Non-posted vectors
        for (int i = 0; i < 4; i++) begin
            fsbGo(npTab[i].a, 16'h7777, npTab[i].we, 1'b0, 1'b0, 1'b0);
            step();
            waitReq("np.req");
            check("np.IORW", 32'(IORW), 32'(!npTab[i].we));
            check("np.IOA", 32'(IOA), 32'(npTab[i].a));
            if (npTab[i].we) check("np.IOD", 32'(IOD), 32'h7777);
            check("np.early", 32'(IONPReady), 0);
            ack();
            done(npTab[i].rd, npTab[i].berr);
            check("np.DO", 32'(DO), 32'(npTab[i].expDO));
            check("np.nBERR", 32'(nBERR_FSB), 32'(npTab[i].expNB));
            check("np.ready", 32'(IONPReady), 32'(npTab[i].expRdy));
            step();
            check("np.nBERRHold", 32'(nBERR_FSB), 32'(npTab[i].expNB));
            fsbEnd();
            check("np.nBERRClr", 32'(nBERR_FSB), 1);
            check("np.readyClr", 32'(IONPReady), 0);
        end

        // Five posted writes with IOACT low: the fifth stalls until the first IODONE
        for (int k = 0; k < 4; k++) postWrite(AW'(32'h100000 + 2 * k), DW'(32'h1000 + k));
        check("full.count", 32'(Count), 4);
        fsbGo(23'h100008, 16'h1004, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("full.stall", 32'(IOPWReady), 0);
        step(); step();
        check("full.stall2", 32'(IOPWReady), 0);
        check("full.count2", 32'(Count), 4);
        waitReq("full.req");
        ack();
        check("full.stall3", 32'(IOPWReady), 0);
        done('0, 1'b0);
        check("full.readyAfterDone", 32'(IOPWReady), 1);
        check("full.countSame", 32'(Count), 4);
        fsbEnd();
        for (int k = 1; k < 5; k++) begin
            waitReq("full.drainReq");
            check("full.drainIOA", 32'(IOA), 32'h100000 + 2 * k);
            check("full.drainIOD", 32'(IOD), 32'h1000 + k);
            ack();
            done('0, 1'b0);
        end
        check("full.empty", 32'(Count), 0);
        check("pwerr.clear", 32'(PWErr), 0);

        // Posted write error
        postWrite(23'h300000, 16'hDEAD);
        waitReq("pwerr.req");
        ack();
        done('0, 1'b1);
        check("pwerr.flag", 32'(PWErr), 1);
        check("pwerr.count", 32'(Count), 0);
        check("pwerr.nBERR", 32'(nBERR_FSB), 1);

        // Steady state at Count=2 with enqueue and retire on the same edge, 3*DEPTH writes
        postWrite(23'h400000, 16'h5000);
        postWrite(23'h400002, 16'h5001);
        check("wrap.count0", 32'(Count), 2);
        for (int i = 2; i < 3 * DEPTH; i++) begin
            waitReq("wrap.req");
            check("wrap.IOA", 32'(IOA), 32'h400000 + 2 * (i - 2));
            check("wrap.IOD", 32'(IOD), 32'h5000 + (i - 2));
            ack();
            fsbGo(AW'(32'h400000 + 2 * i), DW'(32'h5000 + i), 1'b1, 1'b1, 1'b0, 1'b0);
            IODONE = 1'b1;
            step();
            IODONE = 1'b0;
            check("wrap.count", 32'(Count), 2);
            check("wrap.ready", 32'(IOPWReady), 1);
            fsbEnd();
        end
        for (int j = 3 * DEPTH - 2; j < 3 * DEPTH; j++) begin
            waitReq("wrap.tailReq");
            check("wrap.tailIOA", 32'(IOA), 32'h400000 + 2 * j);
            ack();
            done('0, 1'b0);
        end
        check("wrap.empty", 32'(Count), 0);

        // Read aborted while waiting behind a queued write
        postWrite(23'h600000, 16'h6000);
        fsbGo(23'h600100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        fsbEnd();
        waitReq("abort.wreq");
        check("abort.IOA", 32'(IOA), 32'h600000);
        ack();
        done('0, 1'b0);
        repeat (5) step();
        check("abort.noReq", 32'(IOREQ), 0);
        check("abort.noReady", 32'(IONPReady), 0);
        check("abort.count", 32'(Count), 0);

        // Reset while the master is active with three writes queued
        for (int k = 0; k < 3; k++) postWrite(AW'(32'h700000 + 2 * k), DW'(32'h7000 + k));
        waitReq("rst2.req");
        ack();
        check("rst2.countBefore", 32'(Count), 3);
        nRES = 1'b0;
        #1;
        check("rst2.Count", 32'(Count), 0);
        check("rst2.IOREQ", 32'(IOREQ), 0);
        check("rst2.IORW", 32'(IORW), 1);
        check("rst2.IOA", 32'(IOA), 0);
        check("rst2.IOD", 32'(IOD), 0);
        check("rst2.IOL0", 32'(IOL0), 0);
        check("rst2.IOU0", 32'(IOU0), 0);
        check("rst2.PWErr", 32'(PWErr), 0);
        check("rst2.DO", 32'(DO), 0);
        check("rst2.nBERR", 32'(nBERR_FSB), 1);
        step();
        nRES = 1'b1;
        step();
        IODONE = 1'b1;
        step();
        IODONE = 1'b0;
        step(); step();
        check("rst2.lateDoneCount", 32'(Count), 0);
        check("rst2.lateDoneReq", 32'(IOREQ), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
